mm: RTL and testbench
=====================

# mm

Memory-access stage of the CPU pipeline. It sits directly downstream of step_ex and consumes its result, memory-access type/size, address and destination register. Register-to-register results pass through to writeback in one cycle. Loads and stores become a single word-aligned bus transaction with byte enables, with the stage stalling step_ex until the bus acknowledges. Loads are extracted, extended or merged (LWL/LWR) before writeback.

## Interface
Parameters: none. Encodings are defined in defs.v.
- `MEM_ACCESS_TYPE_*`: R2R=0, M2R=1, R2M=2.
- `MEM_ACCESS_LENGTH_*`: WORD=0, BYTE=1, HALF=2, LEFT_WORD=3, RIGHT_WORD=4. Size is 3 bits wide.

Ports:
- clk  in  1  sole clock; everything updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  exception flush, sampled synchronously
- ex_valid  in  1  step_ex presents an instruction
- ex_ready  out  1  stage can accept; the combinational inverse of "busy"
- mem_access_type  in  2  R2R/M2R/R2M
- mem_access_size  in  3  access length
- mem_sign_ext  in  1  1 = sign-extend byte/half loads (LB/LH)
- val_input  in  32  R2R result; store data; old rt value for LWL/LWR
- mem_access_addr  in  32  virtual byte address
- bypass_reg_addr  in  5  destination register
- bus_req  out  1  bus request, held until acknowledged
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_byte_en  out  4  lane enables, bit i = byte i (little-endian)
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle acknowledge
- wb_valid  out  1  one-cycle writeback pulse
- wb_reg_addr  out  5  writeback register
- wb_val  out  32  writeback value
- addr_err  out  1  one-cycle misaligned-address pulse
- bad_vaddr  out  32  faulting address; held until the next error

## Operation
- States are IDLE and BUS. Reset forces IDLE. Reset also zeroes every registered output (bus_*, wb_*, addr_err, bad_vaddr). ex_ready = (state==IDLE).
- An instruction is accepted on a rising edge where ex_valid & ex_ready & ~flush.
- **R2R accept:** in the next cycle wb_valid=1, wb_val=val_input, wb_reg_addr=bypass_reg_addr. State stays IDLE, giving back-to-back throughput.
- **Misaligned accept:** HALF with addr[0]=1, or WORD with addr[1:0]≠0. No bus access occurs. In the next cycle addr_err=1, bad_vaddr=addr and wb_valid=0. BYTE, LEFT_WORD and RIGHT_WORD are never misaligned.
- **Aligned M2R/R2M accept:** latch the operands and go to BUS.
  - bus_req=1 from the next cycle.
  - bus_addr, bus_we, bus_byte_en and bus_wdata stay stable until the edge where bus_ack=1.
  - At that edge: bus_req←0, state←IDLE.
  - For a load: wb_valid←1 with the formatted value.
  - For a store: wb_valid stays 0.
- Define a = addr[1:0].
- **Store lanes:**
  - BYTE: be=1<<a, wdata={4{v[7:0]}}.
  - HALF: be=a[1]?1100:0011, wdata={2{v[15:0]}}.
  - WORD: be=1111, wdata=v.
  - LEFT_WORD (SWL): be=(1<<(a+1))-1, wdata=v>>(8*(3-a)).
  - RIGHT_WORD (SWR): be=(1111<<a)[3:0], wdata=v<<(8*a).
- **Loads:** bus_we=0, be=1111, r=bus_rdata.
  - BYTE: (r>>8a)[7:0], extended per mem_sign_ext.
  - HALF: (r>>16a[1])[15:0], extended per mem_sign_ext.
  - WORD: r.
  - LWL: (r<<8(3-a)) | (v & ~(FFFFFFFF<<8(3-a))).
  - LWR: (r>>8a) | (v & ~(FFFFFFFF>>8a)).
- **Flush in IDLE:** nothing is accepted, and wb_valid/addr_err are 0 in the next cycle.
- **Flush in BUS:** the transaction is not abandoned. bus_req is held until ack, but a kill flag is set and the ack produces no wb_valid. ex_ready returns as usual.
- **Reset mid-transaction:** immediate return to IDLE with bus_req=0. The bus must tolerate the dropped request.

## Timing
- An R2R result appears on wb one cycle after accept.
- For a load with ack in the first request cycle: accept at edge N, bus_req high in cycle N→N+1, ack sampled at edge N+1. wb_valid and ex_ready are high in cycle N+1→N+2. Minimum latency is 2 cycles; each wait cycle adds 1.
- A new accept is possible at the edge after ack (edge N+2). bus_req is therefore low for at least one cycle between transactions.
- wb_valid and addr_err are single-cycle pulses. They are mutually exclusive.
- bus_ack while state=IDLE is ignored.

## Test plan
- **R2R stream:** three back-to-back R2R instructions with v=1,2,3 to r5,r6,r7 → wb pulses on three consecutive cycles; ex_ready is never low.
- **LB/LBU:** addr=0x1003, rdata=0x80FF_0000, one-cycle ack. Sign-extended → wb_val=0xFFFFFF80; zero-extended → 0x00000080. bus_addr=0x1000, be=1111.
- **SH and SWL:** SH with a=2, v=0x1234ABCD → be=1100, wdata=0xABCDABCD. SWL with a=1, v=0xAABBCCDD → be=0011, wdata=0x0000AABB. A 3-cycle ack delay → ex_ready low for 4 cycles and no wb_valid.
- **LWL/LWR merge:** v=0x11223344, rdata=0xAABBCCDD, a=1. LWL → 0xCCDD3344; LWR → 0x11AABBCC.
- **Misaligned LW:** addr=0x2002 → bus_req never asserts; addr_err pulses with bad_vaddr=0x2002; the next instruction is accepted the following cycle.
- **Flush and reset:** flush in BUS → ack completes and no wb_valid. Separately, rst_n low mid-BUS → bus_req drops asynchronously, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mm.sv
// mm: memory-access pipeline stage; R2R pass-through, aligned bus loads/stores with
// byte lanes, load extraction/extension and LWL/LWR merging into writeback.
module mm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  mem_access_type,
  input  logic [2:0]  mem_access_size,
  input  logic        mem_sign_ext,
  input  logic [31:0] val_input,
  input  logic [31:0] mem_access_addr,
  input  logic [4:0]  bypass_reg_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_val,
  output logic        addr_err,
  output logic [31:0] bad_vaddr
);
  localparam logic [1:0] MEM_ACCESS_TYPE_R2R = 2'd0, MEM_ACCESS_TYPE_M2R = 2'd1, MEM_ACCESS_TYPE_R2M = 2'd2;
  localparam logic [2:0] MEM_ACCESS_LENGTH_WORD = 3'd0, MEM_ACCESS_LENGTH_BYTE = 3'd1,
                         MEM_ACCESS_LENGTH_HALF = 3'd2, MEM_ACCESS_LENGTH_LEFT_WORD = 3'd3,
                         MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4;
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_n;
  logic accept, mem_op, misal, kill, lsign;
  logic [1:0] a, la;
  logic [2:0] lsize;
  logic [3:0] be_n;
  logic [4:0] lreg;
  logic [15:0] rh;
  logic [31:0] wd_n, ld_val, rb, lv;
  assign ex_ready = state == IDLE;
  assign accept = ex_valid & ex_ready & ~flush;
  assign a = mem_access_addr[1:0];
  assign mem_op = mem_access_type != MEM_ACCESS_TYPE_R2R;
  assign misal = (mem_access_size == MEM_ACCESS_LENGTH_HALF && a[0]) ||
                 (mem_access_size == MEM_ACCESS_LENGTH_WORD && a != 2'b00);
  always_comb begin
    be_n = mem_access_type == MEM_ACCESS_TYPE_M2R ? 4'hf :
           mem_access_size == MEM_ACCESS_LENGTH_BYTE ? 4'b0001 << a :
           mem_access_size == MEM_ACCESS_LENGTH_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           mem_access_size == MEM_ACCESS_LENGTH_LEFT_WORD ? 4'hf >> ~a :
           mem_access_size == MEM_ACCESS_LENGTH_RIGHT_WORD ? 4'hf << a : 4'hf;
    wd_n = mem_access_size == MEM_ACCESS_LENGTH_BYTE ? {4{val_input[7:0]}} :
           mem_access_size == MEM_ACCESS_LENGTH_HALF ? {2{val_input[15:0]}} :
           mem_access_size == MEM_ACCESS_LENGTH_LEFT_WORD ? val_input >> {~a, 3'b000} :
           mem_access_size == MEM_ACCESS_LENGTH_RIGHT_WORD ? val_input << {a, 3'b000} : val_input;
  end
  // load formatting uses the operands latched at accept
  always_comb begin
    rb = bus_rdata >> {la, 3'b000};
    rh = 16'(bus_rdata >> {la[1], 4'b0000});
    ld_val = lsize == MEM_ACCESS_LENGTH_BYTE ? {{24{lsign & rb[7]}}, rb[7:0]} :
             lsize == MEM_ACCESS_LENGTH_HALF ? {{16{lsign & rh[15]}}, rh} :
             lsize == MEM_ACCESS_LENGTH_LEFT_WORD ?
               (bus_rdata << {~la, 3'b000}) | (lv & ~(32'hffffffff << {~la, 3'b000})) :
             lsize == MEM_ACCESS_LENGTH_RIGHT_WORD ? rb | (lv & ~(32'hffffffff >> {la, 3'b000})) :
             bus_rdata;
  end
  always_comb begin
    state_n = state;
    if (accept && mem_op && !misal) state_n = BUS;
    else if (state == BUS && bus_ack) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_byte_en <= '0;
      bus_wdata <= '0;
      wb_valid <= 1'b0;
      wb_reg_addr <= '0;
      wb_val <= '0;
      addr_err <= 1'b0;
      bad_vaddr <= '0;
      kill <= 1'b0;
      lsign <= 1'b0;
      la <= '0;
      lsize <= '0;
      lreg <= '0;
      lv <= '0;
    end else begin
      wb_valid <= 1'b0;
      addr_err <= 1'b0;
      if (accept && !mem_op) begin
        wb_valid <= 1'b1;
        wb_val <= val_input;
        wb_reg_addr <= bypass_reg_addr;
      end else if (accept && misal) begin
        addr_err <= 1'b1;
        bad_vaddr <= mem_access_addr;
      end else if (accept) begin
        bus_req <= 1'b1;
        bus_we <= mem_access_type == MEM_ACCESS_TYPE_R2M;
        bus_addr <= {mem_access_addr[31:2], 2'b00};
        bus_byte_en <= be_n;
        bus_wdata <= wd_n;
        kill <= 1'b0;
        lsign <= mem_sign_ext;
        la <= a;
        lsize <= mem_access_size;
        lreg <= bypass_reg_addr;
        lv <= val_input;
      end
      // a flushed transaction still completes on the bus but never writes back
      if (state == BUS && flush) kill <= 1'b1;
      if (state == BUS && bus_ack) begin
        bus_req <= 1'b0;
        if (!bus_we && !kill && !flush) begin
          wb_valid <= 1'b1;
          wb_val <= ld_val;
          wb_reg_addr <= lreg;
        end
      end
    end
endmodule

// File: tb/tb_mm.sv
// tb_mm: directed bench for mm with a writeback scoreboard and a hand-driven bus.
module tb_mm;
  localparam logic [1:0] R2R = 2'd0, M2R = 2'd1, R2M = 2'd2;
  localparam logic [2:0] WORD = 3'd0, BYTE = 3'd1, HALF = 3'd2, LWL = 3'd3, LWR = 3'd4;
  logic clk = 1'b0, rst_n, flush, ex_valid, ex_ready, mem_sign_ext;
  logic [1:0] mem_access_type;
  logic [2:0] mem_access_size;
  logic [31:0] val_input, mem_access_addr, bus_addr, bus_wdata, bus_rdata, wb_val, bad_vaddr;
  logic [4:0] bypass_reg_addr, wb_reg_addr;
  logic bus_req, bus_we, bus_ack, wb_valid, addr_err;
  logic [3:0] bus_byte_en;
  logic [36:0] exp_q[$];
  int checks = 0, passes = 0;

  mm dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_sign_ext(mem_sign_ext), .val_input(val_input), .mem_access_addr(mem_access_addr),
    .bypass_reg_addr(bypass_reg_addr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wb_valid(wb_valid),
    .wb_reg_addr(wb_reg_addr), .wb_val(wb_val), .addr_err(addr_err), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // advance one edge; any writeback pulse is matched against the scoreboard
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (wb_valid && exp_q.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'd0);
    else if (wb_valid) begin
      e = exp_q.pop_front();
      chk("wb_reg", 32'(wb_reg_addr), 32'(e[36:32]));
      chk("wb_val", wb_val, e[31:0]);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [2:0] s, input logic se,
                       input logic [31:0] v, input logic [31:0] ad, input logic [4:0] r);
    ex_valid = 1'b1;
    mem_access_type = t;
    mem_access_size = s;
    mem_sign_ext = se;
    val_input = v;
    mem_access_addr = ad;
    bypass_reg_addr = r;
    tick();
    ex_valid = 1'b0;
  endtask

  // called right after an accepting edge; checks request fields, waits, then acks
  task automatic bus_txn(input string tag, input logic [31:0] ad, input logic we,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input logic exp_wb);
    int low = 0;
    chk({tag, "_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_addr"}, bus_addr, ad);
    chk({tag, "_we"}, 32'(bus_we), 32'(we));
    chk({tag, "_be"}, 32'(bus_byte_en), 32'(be));
    if (we) chk({tag, "_wdata"}, bus_wdata, wd);
    for (int i = 0; i < waits; i++) begin
      if (!ex_ready) low++;
      tick();
      chk({tag, "_hold_addr"}, bus_addr, ad);
      chk({tag, "_hold_be"}, 32'(bus_byte_en), 32'(be));
    end
    if (!ex_ready) low++;
    chk({tag, "_ready_low_cycles"}, 32'(low), 32'(waits + 1));
    bus_ack = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(exp_wb));
    chk({tag, "_req_drop"}, 32'(bus_req), 32'd0);
    chk({tag, "_ready"}, 32'(ex_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_sign_ext = 1'b0; bus_ack = 1'b0;
    mem_access_type = R2R; mem_access_size = WORD; val_input = 0; mem_access_addr = 0;
    bypass_reg_addr = 0; bus_rdata = 0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_wb_val", wb_val, 32'd0);
    chk("rst_bad_vaddr", bad_vaddr, 32'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back R2R
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({5'(4 + i), 32'(i)});
      chk("r2r_ready", 32'(ex_ready), 32'd1);
      ex_valid = 1'b1;
      mem_access_type = R2R;
      val_input = 32'(i);
      bypass_reg_addr = 5'(4 + i);
      tick();
      chk("r2r_wb_valid", 32'(wb_valid), 32'd1);
    end
    ex_valid = 1'b0;
    tick();
    chk("r2r_wb_end", 32'(wb_valid), 32'd0);

    // LB / LBU / LH / LW
    exp_q.push_back({5'd8, 32'hFFFFFF80});
    issue(M2R, BYTE, 1'b1, 32'h0, 32'h1003, 5'd8);
    bus_txn("lb", 32'h1000, 1'b0, 4'hf, 32'h0, 32'h80FF0000, 0, 1'b1);
    exp_q.push_back({5'd9, 32'h00000080});
    issue(M2R, BYTE, 1'b0, 32'h0, 32'h1003, 5'd9);
    bus_txn("lbu", 32'h1000, 1'b0, 4'hf, 32'h0, 32'h80FF0000, 0, 1'b1);
    exp_q.push_back({5'd10, 32'hFFFF8001});
    issue(M2R, HALF, 1'b1, 32'h0, 32'h1002, 5'd10);
    bus_txn("lh", 32'h1000, 1'b0, 4'hf, 32'h0, 32'h80011234, 0, 1'b1);
    exp_q.push_back({5'd11, 32'hDEADBEEF});
    issue(M2R, WORD, 1'b0, 32'h0, 32'h1004, 5'd11);
    bus_txn("lw", 32'h1004, 1'b0, 4'hf, 32'h0, 32'hDEADBEEF, 1, 1'b1);

    // stores
    issue(R2M, HALF, 1'b0, 32'h1234ABCD, 32'h3002, 5'd0);
    bus_txn("sh", 32'h3000, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 0, 1'b0);
    issue(R2M, LWL, 1'b0, 32'hAABBCCDD, 32'h3001, 5'd0);
    bus_txn("swl", 32'h3000, 1'b1, 4'b0011, 32'h0000AABB, 32'h0, 3, 1'b0);
    issue(R2M, LWR, 1'b0, 32'hAABBCCDD, 32'h3001, 5'd0);
    bus_txn("swr", 32'h3000, 1'b1, 4'b1110, 32'hBBCCDD00, 32'h0, 0, 1'b0);
    issue(R2M, BYTE, 1'b0, 32'h00000055, 32'h3003, 5'd0);
    bus_txn("sb", 32'h3000, 1'b1, 4'b1000, 32'h55555555, 32'h0, 0, 1'b0);

    // LWL / LWR merge
    exp_q.push_back({5'd12, 32'hCCDD3344});
    issue(M2R, LWL, 1'b0, 32'h11223344, 32'h4001, 5'd12);
    bus_txn("lwl", 32'h4000, 1'b0, 4'hf, 32'h0, 32'hAABBCCDD, 0, 1'b1);
    exp_q.push_back({5'd13, 32'h11AABBCC});
    issue(M2R, LWR, 1'b0, 32'h11223344, 32'h4001, 5'd13);
    bus_txn("lwr", 32'h4000, 1'b0, 4'hf, 32'h0, 32'hAABBCCDD, 0, 1'b1);

    // misaligned LW followed immediately by an R2R
    issue(M2R, WORD, 1'b0, 32'h0, 32'h2002, 5'd14);
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_bad_vaddr", bad_vaddr, 32'h2002);
    chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_wb_valid", 32'(wb_valid), 32'd0);
    chk("mis_ready", 32'(ex_ready), 32'd1);
    exp_q.push_back({5'd15, 32'h77});
    issue(R2R, WORD, 1'b0, 32'h77, 32'h2002, 5'd15);
    chk("mis_next_wb", 32'(wb_valid), 32'd1);
    chk("mis_err_pulse", 32'(addr_err), 32'd0);
    chk("mis_bad_hold", bad_vaddr, 32'h2002);
    issue(R2M, HALF, 1'b0, 32'h0, 32'h2005, 5'd0);
    chk("mis_sh_err", 32'(addr_err), 32'd1);
    chk("mis_sh_vaddr", bad_vaddr, 32'h2005);
    chk("mis_sh_req", 32'(bus_req), 32'd0);

    // flush in IDLE blocks the accept
    flush = 1'b1;
    issue(R2R, WORD, 1'b0, 32'h99, 32'h0, 5'd16);
    flush = 1'b0;
    chk("flush_idle_wb", 32'(wb_valid), 32'd0);
    chk("flush_idle_ready", 32'(ex_ready), 32'd1);

    // flush while on the bus: transaction completes silently
    issue(M2R, WORD, 1'b0, 32'h0, 32'h5000, 5'd17);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus_txn("flush_bus", 32'h5000, 1'b0, 4'hf, 32'h0, 32'h12345678, 0, 1'b0);

    // reset in the middle of a bus transaction
    issue(M2R, WORD, 1'b0, 32'h0, 32'h6000, 5'd18);
    chk("rst_mid_req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus_req), 32'd0);
    chk("rst_mid_ready", 32'(ex_ready), 32'd1);
    chk("rst_mid_addr", bus_addr, 32'h0);
    chk("rst_mid_be", 32'(bus_byte_en), 32'h0);
    chk("rst_mid_wb_val", wb_val, 32'h0);
    chk("rst_mid_bad_vaddr", bad_vaddr, 32'h0);
    rst_n = 1'b1;
    exp_q.push_back({5'd19, 32'hCAFE});
    issue(R2R, WORD, 1'b0, 32'hCAFE, 32'h0, 5'd19);
    chk("post_rst_wb", 32'(wb_valid), 32'd1);
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
